// File: rtl/instr_mem_arb.sv
// Two-requester (fetch/debug) round-robin arbiter in front of a single-port instruction memory.
// Fixed three-stage timing: accept in N, memory strobe in N+1, response in N+2.
module instr_mem_arb #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int unsigned SIZE_B   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  output logic [31:0] f_rdata_o,
  output logic        f_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        flush_i,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [31:0] LAST_OFF = 32'(SIZE_B) - 32'd4;

  // rr_last_d resets high so fetch is preferred on the first conflict
  logic        rr_last_d;
  logic        acc;
  logic [31:0] acc_addr;
  logic [32:0] acc_diff;
  logic        acc_err;

  logic        s1_valid, s1_owner, s1_err;
  logic        s2_valid, s2_owner, s2_err;
  logic        f_live, d_live;

  assign f_gnt_o = rst_ni & f_req_i & (~d_req_i | rr_last_d);
  assign d_gnt_o = rst_ni & d_req_i & (~f_req_i | ~rr_last_d);
  assign acc     = f_gnt_o | d_gnt_o;

  assign acc_addr = d_gnt_o ? d_addr_i : f_addr_i;
  // bit 32 is the borrow, i.e. address below MEM_BASE
  assign acc_diff = {1'b0, acc_addr} - {1'b0, MEM_BASE};
  assign acc_err  = (|acc_addr[1:0]) | acc_diff[32] | (acc_diff[31:0] > LAST_OFF);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_d  <= 1'b1;
      s1_valid   <= 1'b0;
      s1_owner   <= 1'b0;
      s1_err     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_owner   <= 1'b0;
      s2_err     <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= MEM_BASE;
    end else begin
      if (acc) rr_last_d <= d_gnt_o;
      s1_valid <= acc;
      s1_owner <= d_gnt_o;
      s1_err   <= acc_err;
      mem_en_o <= acc & ~acc_err;
      if (acc && !acc_err) mem_addr_o <= acc_addr;
      // a flush squashes a fetch sitting between acceptance and response
      s2_valid <= s1_valid & ~(flush_i & ~s1_owner);
      s2_owner <= s1_owner;
      s2_err   <= s1_err;
    end
  end

  // flush in the response cycle also kills the fetch response presented then
  assign f_live = s2_valid & ~s2_owner & ~flush_i;
  assign d_live = s2_valid & s2_owner;

  assign f_rvalid_o = f_live;
  assign f_err_o    = f_live & s2_err;
  assign f_rdata_o  = (f_live && !s2_err) ? mem_data_i : 32'h0;

  assign d_rvalid_o = d_live;
  assign d_err_o    = d_live & s2_err;
  assign d_rdata_o  = (d_live && !s2_err) ? mem_data_i : 32'h0;

endmodule
